keypad_scanner: RTL and testbench

Scans a 4x4 active-low matrix keypad, debounces the pressed key, and emits a one-cycle strobe with a 4-bit hex code on each new press. It is clocked by the divided `clk` from `slowclock`, sitting directly downstream of it and upstream of the display-update logic. Single-key lockout: while a key is held, no other key is reported.

---
 rtl/keypad_scanner_if.sv | 26 ++
 rtl/keypad_scanner.sv | 214 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-event bundle between keypad_scanner and its neighbours.
// master: the scanner (drives columns, reports keys); slave: keypad/consumer side.
// Pure signal grouping; no clocked logic lives here.
interface keypad_scanner_if;
    logic [3:0] rows;       // active-low row returns, pulled up externally
    logic [3:0] cols;       // active-low one-hot column drive
    logic [3:0] key;        // hex code of the last accepted key
    logic       key_valid;  // one-cycle strobe on a new accepted press
    logic       key_held;   // accepted key still down (HELD or RELEASE)

    modport master (
        input  rows,
        output cols,
        output key,
        output key_valid,
        output key_held
    );

    modport slave (
        output rows,
        input  cols,
        input  key,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with debounce and single-key lockout; optional KEYSCAN_SYNC_EN adds a row synchronizer.
// Latency: key/key_valid DEBOUNCE_CYCLES+1 cycles after the evaluation cycle that first sees the press.
// No backpressure: key_valid is a single-cycle strobe that the consumer must take when it appears.
module keypad_scanner #(
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic             clk,
    input  logic             reset,
    keypad_scanner_if.master kp
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    col_q, col_d;
    logic [1:0]    row_q, row_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [3:0]    cols_q, cols_d;
    logic [3:0]    key_q, key_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;

    // Rows as seen by the decision logic, and whether this SCAN cycle may act on them.
    logic [3:0]    rows_s;
    logic          eval;
    logic [1:0]    low_idx;
    logic          row_lvl;

`ifdef KEYSCAN_SYNC_EN
    logic [3:0] sync1_q, sync2_q;
    logic [1:0] dwell_q, dwell_d;

    // Two-flop synchronizer on the raw row pins; idles at "no key".
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
        end else begin
            sync1_q <= kp.rows;
            sync2_q <= sync1_q;
        end
    end

    assign rows_s = sync2_q;
    // Only the third cycle of a column's dwell sees rows that belong to it.
    assign eval   = (dwell_q == 2'd2);

    // Dwell counter restarts whenever a column is (re)entered in SCAN.
    always_comb begin
        dwell_d = 2'd0;
        if (state_q == ST_SCAN && !eval) begin
            dwell_d = dwell_q + 2'd1;
        end
    end

    // Dwell counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dwell_q <= 2'd0;
        end else begin
            dwell_q <= dwell_d;
        end
    end
`else
    assign rows_s = kp.rows;
    assign eval   = 1'b1;
`endif

    // Map a latched (row, column) position to the keypad legend.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    // Lowest-index low row wins a same-column tie.
    always_comb begin
        low_idx = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!rows_s[r]) begin
                low_idx = 2'(r);
            end
        end
    end

    // Level of the latched row: 0 = key closed, 1 = key open.
    assign row_lvl = rows_s[row_q];

    // State register and scan datapath (column, latched row, debounce counter).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_SCAN;
            col_q   <= 2'd0;
            row_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: scan, debounce the press, hold, debounce the release.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_SCAN: begin
                if (eval) begin
                    if (rows_s != 4'hF) begin
                        row_d   = low_idx;
                        cnt_d   = '0;
                        state_d = ST_DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (row_lvl) begin
                    // Bounce: abandon this key and continue past its column.
                    state_d = ST_SCAN;
                    col_d   = col_q + 2'd1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HELD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_HELD: begin
                if (row_lvl) begin
                    cnt_d   = '0;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!row_lvl) begin
                    // Release bounce: the same key is still down, no new event.
                    state_d = ST_HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_SCAN;
                    col_d   = col_q + 2'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_SCAN;
            end
        endcase
    end

    // Output decode: computed from the next state so every output leaves a flop.
    always_comb begin
        cols_d      = ~(4'b0001 << col_d);
        key_d       = key_q;
        key_valid_d = 1'b0;
        if (state_q == ST_DEBOUNCE && state_d == ST_HELD) begin
            key_d       = key_code(row_q, col_q);
            key_valid_d = 1'b1;
        end
        key_held_d = (state_d == ST_HELD) || (state_d == ST_RELEASE);
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cols_q      <= 4'b1110;
            key_q       <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            cols_q      <= cols_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign kp.cols      = cols_q;
    assign kp.key       = key_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a behavioural keypad drives the row pins from a set of closed keys,
// and each scenario task predicts event timing from the scan/debounce rules with plain arithmetic.
// Default build (1-cycle column dwell, no row synchronizer).
module tb_keypad_scanner;

    localparam int D = 20;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] pressed = 16'h0;   // bit r*4+c = key at row r, column c closed
    logic [3:0]  keymap [16];

    int checks = 0;
    int passed = 0;

    keypad_scanner_if kp();

    keypad_scanner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kp)
    );

    always #5 clk = ~clk;

    // Physical keypad: a closed key pulls its row low while its column is driven low.
    always_comb begin
        kp.rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && kp.cols[c] === 1'b0) begin
                    kp.rows[r] = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    // Wait (bounded) until column c is driven; called and returning at a negedge.
    task automatic wait_col(input int c);
        logic [3:0] want;
        int n;
        want = ~(4'b0001 << c);
        n = 0;
        while (kp.cols !== want && n < 12) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (kp.cols !== want) $display("FAIL wait_col: cols=%b want %b", kp.cols, want);
        else passed++;
    endtask

    // Observe n cycles, counting key_valid pulses and remembering the last reported key.
    task automatic run_obs(input int n, output int pulses, output logic [3:0] k);
        pulses = 0;
        k = kp.key;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (kp.key_valid === 1'b1) begin
                pulses++;
                k = kp.key;
            end
        end
    endtask

    // Open every key and give any release debounce time to finish.
    task automatic settle();
        pressed = 16'h0;
        repeat (2*D + 8) @(negedge clk);
        checks++;
        if (kp.key_held !== 1'b0) $display("FAIL settle_idle: key_held=%b want 0", kp.key_held);
        else passed++;
    endtask

    task automatic test_reset();
        logic [3:0] want;
        int kv;
        reset = 1'b0;
        pressed = 16'h0;
        repeat (3) @(negedge clk);
        checks++;
        if (kp.cols !== 4'b1110) $display("FAIL reset_cols: got %b want 1110", kp.cols); else passed++;
        checks++;
        if (kp.key !== 4'h0) $display("FAIL reset_key: got %h want 0", kp.key); else passed++;
        checks++;
        if (kp.key_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", kp.key_valid); else passed++;
        checks++;
        if (kp.key_held !== 1'b0) $display("FAIL reset_held: got %b want 0", kp.key_held); else passed++;
        reset = 1'b1;
        kv = 0;
        for (int i = 0; i < 9; i++) begin
            want = ~(4'b0001 << (i % 4));
            checks++;
            if (kp.cols !== want) $display("FAIL idle_cols[%0d]: got %b want %b", i, kp.cols, want);
            else passed++;
            if (kp.key_valid !== 1'b0) kv++;
            @(negedge clk);
        end
        checks++;
        if (kv != 0) $display("FAIL idle_valid: got %0d pulses want 0", kv); else passed++;
    endtask

    task automatic test_press();
        int r, c, idx, early, p, h;
        logic [3:0] k, want_cols;
        for (int it = 0; it < 5; it++) begin
            if (it == 0) begin r = 1; c = 1; end
            else begin r = $urandom_range(3); c = $urandom_range(3); end
            idx = r*4 + c;
            repeat ($urandom_range(0, 5)) @(negedge clk);
            wait_col(c);
            pressed[idx] = 1'b1;       // detection cycle T is this one
            early = 0;
            for (int i = 1; i <= D; i++) begin
                @(negedge clk);
                if (kp.key_valid !== 1'b0) early++;
            end
            @(negedge clk);            // cycle T+D+1
            checks++;
            if (early != 0) $display("FAIL press_early: got %0d pulses want 0", early); else passed++;
            checks++;
            if (kp.key_valid !== 1'b1) $display("FAIL press_valid: got %b want 1", kp.key_valid); else passed++;
            checks++;
            if (kp.key !== keymap[idx]) $display("FAIL press_key: got %h want %h", kp.key, keymap[idx]); else passed++;
            checks++;
            if (kp.key_held !== 1'b1) $display("FAIL press_held: got %b want 1", kp.key_held); else passed++;
            @(negedge clk);
            checks++;
            if (kp.key_valid !== 1'b0) $display("FAIL press_pulse_width: got %b want 0", kp.key_valid); else passed++;
            h = $urandom_range(0, 30);
            run_obs(h, p, k);
            checks++;
            if (p != 0) $display("FAIL press_hold_pulses: got %0d want 0", p); else passed++;
            pressed[idx] = 1'b0;       // release cycle R
            for (int i = 1; i <= D; i++) @(negedge clk);
            checks++;
            if (kp.key_held !== 1'b1) $display("FAIL release_early: key_held=%b want 1", kp.key_held); else passed++;
            @(negedge clk);            // cycle R+D+1
            want_cols = ~(4'b0001 << ((c + 1) % 4));
            checks++;
            if (kp.key_held !== 1'b0) $display("FAIL release_held: got %b want 0", kp.key_held); else passed++;
            checks++;
            if (kp.cols !== want_cols) $display("FAIL release_cols: got %b want %b", kp.cols, want_cols); else passed++;
            checks++;
            if (kp.key !== keymap[idx]) $display("FAIL key_holds: got %h want %h", kp.key, keymap[idx]); else passed++;
        end
    endtask

    task automatic test_bounce();
        int p, tot;
        logic [3:0] k;
        wait_col(3);
        tot = 0;
        for (int ph = 0; ph < 5; ph++) begin
            pressed[15] = (ph % 2 == 0);
            run_obs(3, p, k);
            tot += p;
        end
        checks++;
        if (tot != 0) $display("FAIL bounce_pulses: got %0d want 0", tot); else passed++;
        pressed[15] = 1'b1;
        run_obs(D + 12, p, k);
        checks++;
        if (p != 1) $display("FAIL bounce_settle_pulses: got %0d want 1", p); else passed++;
        checks++;
        if (k !== 4'hD) $display("FAIL bounce_key: got %h want d", k); else passed++;
        settle();
    endtask

    task automatic test_lockout();
        int a, b, ca, cb, off, p, pc;
        logic [3:0] k;
        for (int it = 0; it < 3; it++) begin
            if (it == 0) begin a = 0; b = 10; end   // "1" then "9"
            else begin
                a = $urandom_range(15);
                b = (a + $urandom_range(1, 15)) % 16;
            end
            ca = a % 4;
            cb = b % 4;
            wait_col(ca);
            pressed[a] = 1'b1;
            run_obs(D + 1, p, k);
            checks++;
            if (p != 1 || k !== keymap[a]) $display("FAIL lock_first: pulses=%0d key=%h want 1 pulse key %h", p, k, keymap[a]);
            else passed++;
            pressed[b] = 1'b1;
            run_obs(25, p, k);
            checks++;
            if (p != 0) $display("FAIL lock_second_hidden: got %0d pulses want 0", p); else passed++;
            checks++;
            if (kp.key !== keymap[a] || kp.key_held !== 1'b1)
                $display("FAIL lock_hold: key=%h held=%b want %h 1", kp.key, kp.key_held, keymap[a]);
            else passed++;
            pressed[a] = 1'b0;         // release cycle R
            off = 2*D + 2 + ((cb - ca + 3) % 4);
            pc = 0;
            for (int i = 1; i < off; i++) begin
                @(negedge clk);
                if (kp.key_valid !== 1'b0) pc++;
            end
            @(negedge clk);
            checks++;
            if (pc != 0) $display("FAIL lock_early: got %0d pulses want 0", pc); else passed++;
            checks++;
            if (kp.key_valid !== 1'b1 || kp.key !== keymap[b])
                $display("FAIL lock_second: valid=%b key=%h want 1 %h", kp.key_valid, kp.key, keymap[b]);
            else passed++;
            settle();
        end
    endtask

    task automatic test_tie();
        int c, mask, lo, p, ry, rx;
        logic [3:0] k;
        // Column 2 with rows 0 and 2 closed: row 0 ("3") wins.
        wait_col(2);
        pressed[2] = 1'b1;
        pressed[10] = 1'b1;
        run_obs(D + 1, p, k);
        checks++;
        if (p != 1 || k !== 4'h3) $display("FAIL tie_fixed: pulses=%0d key=%h want 1 3", p, k); else passed++;
        settle();
        for (int it = 0; it < 3; it++) begin
            c = $urandom_range(3);
            do mask = $urandom_range(15); while ($countones(mask) < 2);
            lo = 0;
            while (((mask >> lo) & 1) == 0) lo++;
            wait_col(c);
            for (int r = 0; r < 4; r++) if ((mask >> r) & 1) pressed[r*4+c] = 1'b1;
            run_obs(D + 1, p, k);
            checks++;
            if (p != 1 || k !== keymap[lo*4+c])
                $display("FAIL tie_row: pulses=%0d key=%h want 1 %h", p, k, keymap[lo*4+c]);
            else passed++;
            settle();
        end
        // Two columns closed at once: the one scanned next wins.
        c = $urandom_range(3);
        ry = $urandom_range(3);
        rx = $urandom_range(3);
        wait_col(c);
        pressed[ry*4 + (c+1)%4] = 1'b1;
        pressed[rx*4 + (c+2)%4] = 1'b1;
        run_obs(D + 2, p, k);
        checks++;
        if (p != 1 || k !== keymap[ry*4 + (c+1)%4])
            $display("FAIL tie_col: pulses=%0d key=%h want 1 %h", p, k, keymap[ry*4 + (c+1)%4]);
        else passed++;
        settle();
    endtask

    task automatic test_midreset();
        int r, c, idx, pc;
        r = $urandom_range(3);
        c = $urandom_range(1, 3);
        if (r == 3 && c == 1) r = 0;
        idx = r*4 + c;
        wait_col(c);
        pressed[idx] = 1'b1;           // detection cycle T
        pc = 0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (kp.key_valid !== 1'b0) pc++;
        end
        reset = 1'b0;                  // debounce counter is 10 here
        #1;
        checks++;
        if (kp.cols !== 4'b1110 || kp.key !== 4'h0 || kp.key_valid !== 1'b0 || kp.key_held !== 1'b0)
            $display("FAIL midreset_outputs: cols=%b key=%h valid=%b held=%b want 1110 0 0 0",
                     kp.cols, kp.key, kp.key_valid, kp.key_held);
        else passed++;
        checks++;
        if (pc != 0) $display("FAIL midreset_pulse: got %0d pulses want 0", pc); else passed++;
        repeat (3) @(negedge clk);
        reset = 1'b1;                  // fresh scan starts at column 0
        pc = 0;
        for (int i = 1; i <= c + D; i++) begin
            @(negedge clk);
            if (kp.key_valid !== 1'b0) pc++;
        end
        @(negedge clk);
        checks++;
        if (pc != 0 || kp.key_valid !== 1'b1 || kp.key !== keymap[idx])
            $display("FAIL midreset_redetect: early=%0d valid=%b key=%h want 0 1 %h",
                     pc, kp.key_valid, kp.key, keymap[idx]);
        else passed++;
        settle();
    endtask

    initial begin
        keymap = '{4'h1, 4'h2, 4'h3, 4'hA,
                   4'h4, 4'h5, 4'h6, 4'hB,
                   4'h7, 4'h8, 4'h9, 4'hC,
                   4'hE, 4'h0, 4'hF, 4'hD};
        test_reset();
        test_press();
        test_bounce();
        test_lockout();
        test_tie();
        test_midreset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
